// File: rtl/aes_output_serializer.sv
// Captures a 128-bit ciphertext on a rising engine_done_i and streams it out MSB byte first.
// Latency: first byte valid 1 clk after the done rise is sampled; 1 byte/clk with dout_ready high.
// Backpressure: dout/dout_last hold while dout_valid & ~dout_ready; a block arriving mid-send is dropped and flagged.
module aes_output_serializer #(
    parameter int BYTE_W    = 8,
    parameter int NUM_BYTES = 16
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic [127:0]      ciphertext_i,
    input  logic              engine_done_i,
    output logic [BYTE_W-1:0] dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              dout_last,
    output logic              busy,
    output logic              overrun
);

    localparam int                CNT_W    = $clog2(NUM_BYTES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_BYTES - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [127:0]     shreg, shreg_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             done_q;
    logic             overrun_nxt;
    logic             done_rise;
    logic             xfer;
    logic             last_beat;

    assign done_rise  = engine_done_i & ~done_q;
    assign dout_valid = (state == SEND);
    assign busy       = (state == SEND);
    assign last_beat  = (cnt == CNT_LAST);
    assign dout_last  = dout_valid & last_beat;
    assign dout       = dout_valid ? shreg[127 -: BYTE_W] : '0;
    assign xfer       = dout_valid & dout_ready;

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state   <= IDLE;
            shreg   <= '0;
            cnt     <= '0;
            done_q  <= 1'b0;
            overrun <= 1'b0;
        end else begin
            state   <= state_nxt;
            shreg   <= shreg_nxt;
            cnt     <= cnt_nxt;
            done_q  <= engine_done_i;
            overrun <= overrun_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        shreg_nxt   = shreg;
        cnt_nxt     = cnt;
        overrun_nxt = overrun;
        unique case (state)
            IDLE: begin
                if (done_rise) begin
                    shreg_nxt = ciphertext_i;
                    cnt_nxt   = '0;
                    state_nxt = SEND;
                end
            end
            SEND: begin
                if (xfer && last_beat) begin
                    // A block arriving exactly on the final beat is taken with no bubble.
                    if (done_rise) begin
                        shreg_nxt = ciphertext_i;
                        cnt_nxt   = '0;
                    end else begin
                        shreg_nxt = shreg << BYTE_W;
                        cnt_nxt   = '0;
                        state_nxt = IDLE;
                    end
                end else begin
                    if (xfer) begin
                        shreg_nxt = shreg << BYTE_W;
                        cnt_nxt   = cnt + CNT_W'(1);
                    end
                    if (done_rise) begin
                        overrun_nxt = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_aes_output_serializer.sv
// Directed bench for aes_output_serializer with a byte scoreboard checked on every transfer.
module tb_aes_output_serializer;

    logic         clk;
    logic         rst_;
    logic [127:0] ciphertext_i;
    logic         engine_done_i;
    logic [7:0]   dout;
    logic         dout_valid;
    logic         dout_ready;
    logic         dout_last;
    logic         busy;
    logic         overrun;

    aes_output_serializer #(.BYTE_W(8), .NUM_BYTES(16)) dut (
        .clk           (clk),
        .rst_          (rst_),
        .ciphertext_i  (ciphertext_i),
        .engine_done_i (engine_done_i),
        .dout          (dout),
        .dout_valid    (dout_valid),
        .dout_ready    (dout_ready),
        .dout_last     (dout_last),
        .busy          (busy),
        .overrun       (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         pass_cnt  = 0;
    int         total_cnt = 0;
    int         xfer_cnt  = 0;
    logic [8:0] sb_q[$];

    logic       held_vld;
    logic [7:0] held_dat;
    logic       held_last;

    localparam logic [127:0] FIPS_CT = 128'h3925841d02dc09fbdc118597196a0b32;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic push_block(input logic [127:0] data);
        logic [127:0] d;
        d = data;
        for (int i = 0; i < 16; i++) begin
            sb_q.push_back({(i == 15), d[127 - 8*i -: 8]});
        end
    endtask

    // Drives a 1-clk done pulse; returns 1 time unit after the edge that samples it.
    task automatic pulse_done(input logic [127:0] data);
        ciphertext_i  = data;
        engine_done_i = 1'b1;
        @(posedge clk);
        #1;
        engine_done_i = 1'b0;
    endtask

    task automatic wait_drain(input int budget, input bit rnd);
        for (int c = 0; c < budget; c++) begin
            if (sb_q.size() == 0) break;
            @(posedge clk);
            #1;
            if (rnd) dout_ready = 1'($urandom_range(0, 1));
        end
        dout_ready = 1'b1;
        chk("drain_empty", 32'(sb_q.size()), 32'd0);
    endtask

    // Scoreboard monitor: compares each accepted byte and checks stall stability.
    always @(negedge clk) begin
        logic [8:0] exp;
        if (!rst_) begin
            held_vld = 1'b0;
        end else begin
            if (held_vld) begin
                chk("stall_valid", 32'(dout_valid), 32'd1);
                chk("stall_dout", 32'(dout), 32'(held_dat));
                chk("stall_last", 32'(dout_last), 32'(held_last));
            end
            if (dout_valid && dout_ready) begin
                if (sb_q.size() == 0) begin
                    chk("extra_byte", 32'(sb_q.size()), 32'd1);
                end else begin
                    exp = sb_q.pop_front();
                    chk("byte", 32'(dout), 32'(exp[7:0]));
                    chk("last", 32'(dout_last), 32'(exp[8]));
                    xfer_cnt++;
                end
            end
            held_vld  = dout_valid & ~dout_ready;
            held_dat  = dout;
            held_last = dout_last;
        end
    end

    initial begin
        int base;
        rst_          = 1'b0;
        engine_done_i = 1'b0;
        ciphertext_i  = FIPS_CT;
        dout_ready    = 1'b1;

        // Reset with done toggling.
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            engine_done_i = ~engine_done_i;
        end
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_valid", 32'(dout_valid), 32'd0);
        chk("rst_last", 32'(dout_last), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        engine_done_i = 1'b0;
        @(posedge clk);
        #1;
        rst_ = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("idle_valid", 32'(dout_valid), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);

        // FIPS-197 vector, ready held high: 16 consecutive bytes then idle.
        push_block(FIPS_CT);
        pulse_done(FIPS_CT);
        @(negedge clk);
        chk("lat_valid", 32'(dout_valid), 32'd1);
        chk("first_byte", 32'(dout), 32'h39);
        chk("first_busy", 32'(busy), 32'd1);
        for (int i = 1; i < 16; i++) begin
            @(negedge clk);
            chk("burst_valid", 32'(dout_valid), 32'd1);
        end
        chk("final_byte", 32'(dout), 32'h32);
        chk("final_last", 32'(dout_last), 32'd1);
        @(negedge clk);
        chk("post_valid", 32'(dout_valid), 32'd0);
        chk("post_queue", 32'(sb_q.size()), 32'd0);

        // Backpressure with random ready.
        @(posedge clk);
        #1;
        push_block(FIPS_CT);
        pulse_done(FIPS_CT);
        wait_drain(300, 1'b1);
        @(negedge clk);
        chk("bp_valid", 32'(dout_valid), 32'd0);

        // Level done held for 40 clks sends one block; a new rise sends another.
        @(posedge clk);
        #1;
        push_block(128'h00112233445566778899aabbccddeeff);
        ciphertext_i  = 128'h00112233445566778899aabbccddeeff;
        engine_done_i = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        engine_done_i = 1'b0;
        chk("level_queue", 32'(sb_q.size()), 32'd0);
        chk("level_valid", 32'(dout_valid), 32'd0);
        chk("level_overrun", 32'(overrun), 32'd0);
        @(posedge clk);
        #1;
        push_block(128'hfedcba98765432100123456789abcdef);
        ciphertext_i  = 128'hfedcba98765432100123456789abcdef;
        engine_done_i = 1'b1;
        wait_drain(60, 1'b0);
        engine_done_i = 1'b0;
        @(negedge clk);
        chk("level2_valid", 32'(dout_valid), 32'd0);

        // Overrun: a rise mid-block is dropped and flagged.
        @(posedge clk);
        #1;
        base = xfer_cnt;
        push_block(128'ha0a1a2a3a4a5a6a7a8a9aaabacadaeaf);
        pulse_done(128'ha0a1a2a3a4a5a6a7a8a9aaabacadaeaf);
        for (int c = 0; c < 40; c++) begin
            if (xfer_cnt >= base + 5) break;
            @(posedge clk);
            #1;
        end
        chk("ovr_reach5", 32'(xfer_cnt - base), 32'd5);
        pulse_done(128'h5555_5555_5555_5555_5555_5555_5555_5555);
        @(negedge clk);
        chk("ovr_flag", 32'(overrun), 32'd1);
        chk("ovr_busy", 32'(busy), 32'd1);
        wait_drain(60, 1'b0);
        repeat (5) @(negedge clk);
        chk("ovr_no_second", 32'(dout_valid), 32'd0);
        chk("ovr_count", 32'(xfer_cnt - base), 32'd16);

        // Back-to-back: rise coincident with the last transfer.
        @(posedge clk);
        #1;
        push_block(128'h0f0e0d0c0b0a09080706050403020100);
        pulse_done(128'h0f0e0d0c0b0a09080706050403020100);
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (dout_valid && dout_last) break;
        end
        chk("b2b_last_seen", 32'(dout_last), 32'd1);
        push_block(128'hc0c1c2c3c4c5c6c7c8c9cacbcccdcecf);
        ciphertext_i  = 128'hc0c1c2c3c4c5c6c7c8c9cacbcccdcecf;
        engine_done_i = 1'b1;
        @(posedge clk);
        #1;
        engine_done_i = 1'b0;
        @(negedge clk);
        chk("b2b_valid", 32'(dout_valid), 32'd1);
        chk("b2b_byte0", 32'(dout), 32'hc0);
        chk("b2b_overrun", 32'(overrun), 32'd1);
        wait_drain(60, 1'b0);
        @(negedge clk);
        chk("b2b_idle", 32'(dout_valid), 32'd0);

        // Reset after byte 7 discards the block; a fresh block follows from byte 0.
        @(posedge clk);
        #1;
        base = xfer_cnt;
        push_block(128'h1111222233334444555566667777aaaa);
        pulse_done(128'h1111222233334444555566667777aaaa);
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            if (xfer_cnt >= base + 7) break;
        end
        #1;
        chk("mid_reach7", 32'(xfer_cnt - base), 32'd7);
        rst_ = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(dout_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_overrun", 32'(overrun), 32'd0);
        chk("mid_rst_dout", 32'(dout), 32'd0);
        sb_q.delete();
        repeat (3) @(posedge clk);
        #1;
        rst_ = 1'b1;
        repeat (3) @(negedge clk);
        chk("mid_release_idle", 32'(dout_valid), 32'd0);
        @(posedge clk);
        #1;
        base = xfer_cnt;
        push_block(128'hdeadbeef0123456789abcdef01020304);
        pulse_done(128'hdeadbeef0123456789abcdef01020304);
        @(negedge clk);
        chk("mid_new_byte0", 32'(dout), 32'hde);
        wait_drain(60, 1'b0);
        chk("mid_new_count", 32'(xfer_cnt - base), 32'd16);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
